cs_loader: RTL and testbench



---
 rtl/cs_loader.sv | 178 +++++++++++++++++
 tb/tb_cs_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_loader.sv
// Startup sequencer: copies the microcode EPROM into control-store RAM, optionally
// verifies it by readback, then releases the control store to the microsequencer.
module cs_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int ROM_WAIT   = 2,
  parameter int VERIFY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] cs_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram__w,
  output logic                  owns_cs,
  output logic                  cs_ready,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] error_addr
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR    = 4'd1;
  localparam logic [3:0] S_WAIT    = 4'd2;
  localparam logic [3:0] S_WRITE   = 4'd3;
  localparam logic [3:0] S_RECOVER = 4'd4;
  localparam logic [3:0] S_VADDR   = 4'd5;
  localparam logic [3:0] S_VWAIT   = 4'd6;
  localparam logic [3:0] S_VCMP    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;

  localparam int CNT_W = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_WAIT - 1);

  logic [3:0]            state_q,      state_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [ADDR_WIDTH-1:0] cs_addr_q,    cs_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;
  logic                  ram__w_q,     ram__w_d;
  logic                  owns_cs_q,    owns_cs_d;
  logic                  cs_ready_q,   cs_ready_d;
  logic                  load_error_q, load_error_d;
  logic [ADDR_WIDTH-1:0] error_addr_q, error_addr_d;

  logic last_addr;
  assign last_addr = &cs_addr_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cs_addr_d    = cs_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram__w_d     = 1'b1;
    owns_cs_d    = owns_cs_q;
    cs_ready_d   = cs_ready_q;
    load_error_d = load_error_q;
    error_addr_d = error_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ADDR;
          cs_addr_d = '0;
          owns_cs_d = 1'b1;
        end
      end
      S_ADDR: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = S_WRITE;
          ram_wdata_d = rom_data;
          ram__w_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_RECOVER;
      end
      // The last word ends the pass here rather than wrapping, so word 0 is never rewritten.
      S_RECOVER: begin
        if (last_addr) begin
          cs_addr_d = '0;
          if (VERIFY != 0) begin
            state_d = S_VADDR;
          end else begin
            state_d    = S_DONE;
            owns_cs_d  = 1'b0;
            cs_ready_d = 1'b1;
          end
        end else begin
          cs_addr_d = cs_addr_q + 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_VADDR: begin
        state_d = S_VWAIT;
        cnt_d   = '0;
      end
      S_VWAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_VCMP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VCMP: begin
        if (rom_data != ram_rdata) begin
          state_d      = S_ERROR;
          load_error_d = 1'b1;
          error_addr_d = cs_addr_q;
        end else if (last_addr) begin
          state_d    = S_DONE;
          cs_addr_d  = '0;
          owns_cs_d  = 1'b0;
          cs_ready_d = 1'b1;
        end else begin
          cs_addr_d = cs_addr_q + 1'b1;
          state_d   = S_VADDR;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_ERROR: begin
        if (start) begin
          state_d      = S_ADDR;
          cs_addr_d    = '0;
          owns_cs_d    = 1'b1;
          load_error_d = 1'b0;
          error_addr_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        owns_cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cs_addr_q    <= '0;
      ram_wdata_q  <= '0;
      ram__w_q     <= 1'b1;
      owns_cs_q    <= 1'b0;
      cs_ready_q   <= 1'b0;
      load_error_q <= 1'b0;
      error_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cs_addr_q    <= cs_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram__w_q     <= ram__w_d;
      owns_cs_q    <= owns_cs_d;
      cs_ready_q   <= cs_ready_d;
      load_error_q <= load_error_d;
      error_addr_q <= error_addr_d;
    end
  end

  assign cs_addr    = cs_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram__w     = ram__w_q;
  assign owns_cs    = owns_cs_q;
  assign cs_ready   = cs_ready_q;
  assign load_error = load_error_q;
  assign error_addr = error_addr_q;

endmodule

// File: tb/tb_cs_loader.sv
// Self-checking bench for cs_loader: behavioural ROM/RAM models, write-pulse monitors
// and edge-count expectations derived from the per-word cycle costs.
module tb_cs_loader;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 256;
  localparam int RW1   = 2;
  localparam int RW2   = 1;

  logic clk;
  logic reset;
  logic start, start2;
  logic fault_en;

  logic [AW-1:0] cs_addr, error_addr, cs_addr2, error_addr2;
  logic [DW-1:0] rom_data, ram_rdata, ram_wdata, rom_data2, ram_rdata2, ram_wdata2;
  logic          ram__w, owns_cs, cs_ready, load_error;
  logic          ram__w2, owns_cs2, cs_ready2, load_error2;

  logic [DW-1:0] rom_mem  [DEPTH];
  logic [DW-1:0] ram_mem  [DEPTH];
  logic [DW-1:0] ram2_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WAIT(RW1), .VERIFY(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_data(rom_data), .ram_rdata(ram_rdata),
    .cs_addr(cs_addr), .ram_wdata(ram_wdata), .ram__w(ram__w),
    .owns_cs(owns_cs), .cs_ready(cs_ready),
    .load_error(load_error), .error_addr(error_addr)
  );

  cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WAIT(RW2), .VERIFY(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .rom_data(rom_data2), .ram_rdata(ram_rdata2),
    .cs_addr(cs_addr2), .ram_wdata(ram_wdata2), .ram__w(ram__w2),
    .owns_cs(owns_cs2), .cs_ready(cs_ready2),
    .load_error(load_error2), .error_addr(error_addr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories; the fault flips bit 0 of word 0x5A on readback only.
  assign rom_data   = rom_mem[cs_addr];
  assign ram_rdata  = ram_mem[cs_addr] ^ ((fault_en && cs_addr == 8'h5A) ? 64'h1 : 64'h0);
  assign rom_data2  = rom_mem[cs_addr2];
  assign ram_rdata2 = ram2_mem[cs_addr2];

  always @(posedge clk) begin
    if (ram__w === 1'b0) ram_mem[cs_addr] <= ram_wdata;
    if (ram__w2 === 1'b0) ram2_mem[cs_addr2] <= ram_wdata2;
  end

  int  wr_cnt, wide_cnt, seq_err, data_err, last_wr;
  int  wr_cnt2, wide_cnt2, seq_err2, data_err2, last_wr2;
  logic prev_low = 1'b0, prev_low2 = 1'b0;

  // Write-pulse monitors: the n-th pulse of a pass must target address n with ROM data.
  always @(negedge clk) begin
    if (ram__w === 1'b0) begin
      if (prev_low) wide_cnt++;
      if (int'(cs_addr) != wr_cnt) seq_err++;
      if (ram_wdata !== rom_mem[cs_addr]) data_err++;
      last_wr = int'(cs_addr);
      wr_cnt++;
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
    if (ram__w2 === 1'b0) begin
      if (prev_low2) wide_cnt2++;
      if (int'(cs_addr2) != wr_cnt2) seq_err2++;
      if (ram_wdata2 !== rom_mem[cs_addr2]) data_err2++;
      last_wr2 = int'(cs_addr2);
      wr_cnt2++;
      prev_low2 = 1'b1;
    end else begin
      prev_low2 = 1'b0;
    end
  end

  task automatic clearMonitors();
    wr_cnt = 0; wide_cnt = 0; seq_err = 0; data_err = 0; last_wr = -1;
    wr_cnt2 = 0; wide_cnt2 = 0; seq_err2 = 0; data_err2 = 0; last_wr2 = -1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raises start so it is sampled on the next rising edge (edge 1), returns 1 unit after it.
  task automatic applyStimulus(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1;
    else     start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic runToEnd(input bit sel, input int limit, input int poke_at, output int edges);
    edges = 1;
    while (!(sel ? (cs_ready2 === 1'b1) : (cs_ready === 1'b1 || load_error === 1'b1)) && edges < limit) begin
      if (poke_at != 0) start = (edges == poke_at);
      @(posedge clk);
      edges++;
      #1;
    end
    start = 1'b0;
  endtask

  function automatic int ramDiffs(input bit sel);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel ? (ram2_mem[i] !== rom_mem[i]) : (ram_mem[i] !== rom_mem[i])) n++;
    end
    return n;
  endfunction

  task automatic scrambleRam();
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]  = ~rom_mem[i];
      ram2_mem[i] = ~rom_mem[i];
    end
  endtask

  initial begin
    int edges, exp_edges, exp_err;
    logic [31:0] seed;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; fault_en = 1'b0;
    clearMonitors();
    seed = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = {seed ^ (32'(i) * 32'h9E3779B9), ~seed ^ (32'(i) * 32'h85EBCA6B)};
    end
    scrambleRam();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cs_addr", cs_addr, 0);
    checkOutput("reset ram_wdata", ram_wdata, 0);
    checkOutput("reset ram__w", ram__w, 1);
    checkOutput("reset owns_cs", owns_cs, 0);
    checkOutput("reset cs_ready", cs_ready, 0);
    checkOutput("reset load_error", load_error, 0);
    checkOutput("reset error_addr", error_addr, 0);
    checkOutput("reset dut2 ram__w", ram__w2, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);

    // Clean load, with a stray start during WAIT of word 0x10 (sampled on edge 83).
    $display("[TB] clean load");
    clearMonitors();
    applyStimulus(1'b0);
    checkOutput("owns_cs after start", owns_cs, 1);
    exp_edges = 1 + DEPTH * (RW1 + 3) + DEPTH * (RW1 + 2);
    runToEnd(1'b0, 3000, 1 + 16 * (RW1 + 3) + 1, edges);
    checkOutput("clean ready edge", edges, exp_edges);
    checkOutput("clean cs_ready", cs_ready, 1);
    checkOutput("clean owns_cs", owns_cs, 0);
    checkOutput("clean load_error", load_error, 0);
    checkOutput("clean cs_addr", cs_addr, 0);
    checkOutput("clean write count", wr_cnt, DEPTH);
    checkOutput("clean wide pulses", wide_cnt, 0);
    checkOutput("clean addr sequence", seq_err, 0);
    checkOutput("clean write data", data_err, 0);
    checkOutput("clean ram image", ramDiffs(1'b0), 0);

    // start in DONE is ignored.
    clearMonitors();
    applyStimulus(1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("done cs_ready held", cs_ready, 1);
    checkOutput("done owns_cs", owns_cs, 0);
    checkOutput("done no writes", wr_cnt, 0);
    checkOutput("done ram__w", ram__w, 1);

    // Verify failure at word 0x5A.
    $display("[TB] verify failure");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    scrambleRam();
    fault_en = 1'b1;
    exp_err = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_err < 0 && (rom_mem[i] ^ ((i == 'h5A) ? 64'h1 : 64'h0)) !== rom_mem[i]) exp_err = i;
    end
    clearMonitors();
    applyStimulus(1'b0);
    exp_edges = 1 + DEPTH * (RW1 + 3) + (exp_err + 1) * (RW1 + 2);
    runToEnd(1'b0, 3000, 0, edges);
    checkOutput("error entry edge", edges, exp_edges);
    checkOutput("error load_error", load_error, 1);
    checkOutput("error error_addr", error_addr, exp_err);
    checkOutput("error cs_ready", cs_ready, 0);
    checkOutput("error ram__w", ram__w, 1);
    checkOutput("error owns_cs", owns_cs, 1);
    checkOutput("error write count", wr_cnt, DEPTH);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("error sticky", load_error, 1);
    checkOutput("error addr sticky", error_addr, exp_err);

    fault_en = 1'b0;
    scrambleRam();
    clearMonitors();
    applyStimulus(1'b0);
    checkOutput("restart load_error cleared", load_error, 0);
    checkOutput("restart error_addr cleared", error_addr, 0);
    runToEnd(1'b0, 3000, 0, edges);
    checkOutput("reload ready edge", edges, 1 + DEPTH * (RW1 + 3) + DEPTH * (RW1 + 2));
    checkOutput("reload cs_ready", cs_ready, 1);
    checkOutput("reload load_error", load_error, 0);
    checkOutput("reload write count", wr_cnt, DEPTH);
    checkOutput("reload ram image", ramDiffs(1'b0), 0);

    // Asynchronous reset during the write of word 0x40.
    $display("[TB] reset mid-load");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    scrambleRam();
    clearMonitors();
    applyStimulus(1'b0);
    edges = 1;
    while (!(ram__w === 1'b0 && cs_addr == 8'h40) && edges < 2000) begin
      @(posedge clk);
      edges++;
      #1;
    end
    checkOutput("write 0x40 edge", edges, 1 + 'h40 * (RW1 + 3) + 1 + RW1);
    reset = 1'b1;
    #1;
    checkOutput("async ram__w", ram__w, 1);
    checkOutput("async cs_addr", cs_addr, 0);
    checkOutput("async ram_wdata", ram_wdata, 0);
    checkOutput("async owns_cs", owns_cs, 0);
    checkOutput("async cs_ready", cs_ready, 0);
    checkOutput("async load_error", load_error, 0);
    checkOutput("async error_addr", error_addr, 0);
    @(negedge clk); reset = 1'b0;
    scrambleRam();
    clearMonitors();
    applyStimulus(1'b0);
    runToEnd(1'b0, 3000, 0, edges);
    checkOutput("post-reset ready edge", edges, 1 + DEPTH * (RW1 + 3) + DEPTH * (RW1 + 2));
    checkOutput("post-reset write count", wr_cnt, DEPTH);
    checkOutput("post-reset ram image", ramDiffs(1'b0), 0);

    // Copy-only instance with a single wait cycle.
    $display("[TB] copy-only load");
    clearMonitors();
    applyStimulus(1'b1);
    runToEnd(1'b1, 2000, 0, edges);
    checkOutput("nv ready edge", edges, 1 + DEPTH * (RW2 + 3));
    checkOutput("nv cs_ready", cs_ready2, 1);
    checkOutput("nv owns_cs", owns_cs2, 0);
    checkOutput("nv last write addr", last_wr2, DEPTH - 1);
    checkOutput("nv write data", data_err2, 0);
    checkOutput("nv wide pulses", wide_cnt2, 0);
    checkOutput("nv addr sequence", seq_err2, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("nv write count", wr_cnt2, DEPTH);
    checkOutput("nv ram image", ramDiffs(1'b1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
